// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the CPU memory bus and its responders.
// Holds bus command encodings, timer register offsets and bit indices,
// the timer run-state enum and the fixed LED/switch addresses so every
// decoder in the top level uses one source.
package mmio_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CMD_W  = 2;

  // Bus commands
  localparam logic [CMD_W-1:0] MNONE  = 2'b00;
  localparam logic [CMD_W-1:0] MREAD  = 2'b01;
  localparam logic [CMD_W-1:0] MWRITE = 2'b10;

  // Timer register offsets from BASE_ADDR
  localparam logic [2:0] TCTRL_OFS  = 3'd0;
  localparam logic [2:0] TLOAD_OFS  = 3'd1;
  localparam logic [2:0] TCOUNT_OFS = 3'd2;
  localparam logic [2:0] TSTAT_OFS  = 3'd3;
  localparam logic [2:0] TCMP_OFS   = 3'd4;

  // TCTRL / TSTAT bit positions
  localparam int unsigned TCTRL_EN_BIT  = 0;
  localparam int unsigned TCTRL_AR_BIT  = 1;
  localparam int unsigned TCTRL_IE_BIT  = 2;
  localparam int unsigned TSTAT_EXP_BIT = 0;

  // Other responders already on the bus
  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

  // Address hit for an 8-aligned block whose top mapped offset is last_ofs.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [2:0]        last_ofs);
    return (addr[ADDR_W-1:3] == base[ADDR_W-1:3]) && (addr[2:0] <= last_ofs);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk into one-cycle ticks every PRESCALE cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   clr   - synchronous restart of the divider at 0
//   en    - count enable; the divider holds while low
//   tick  - high during the cycle where the divider sits at PRESCALE-1
module timer_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap at PRESCALE-1; clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer responding on the CPU bus.
// Registers at BASE_ADDR+0..+3 (TCTRL, TLOAD, TCOUNT, TSTAT) and, when
// TIMER_PWM_EN is defined, TCMP at +4 driving a registered PWM output.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   mem_cmd    - bus command (MNONE/MREAD/MWRITE)
//   mem_addr   - bus address
//   write_data - write data from the CPU
//   read_data  - combinational read data, high-impedance when not selected
//   timer_irq  - registered EXP & IE
//   pwm_out    - registered PWM output (tied low without TIMER_PWM_EN)
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [8:0]  BASE_ADDR = 9'h180,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              timer_irq,
  output logic              pwm_out
);

`ifdef TIMER_PWM_EN
  localparam logic [2:0] LAST_OFS = TCMP_OFS;
`else
  localparam logic [2:0] LAST_OFS = TSTAT_OFS;
`endif

  tmr_state_e        state_q, state_d;
  logic              ar_q, ar_d;
  logic              ie_q, ie_d;
  logic [DATA_W-1:0] tload_q, tload_d;
  logic [DATA_W-1:0] tcount_q, tcount_d;
  logic              exp_q, exp_d;
  logic              irq_q, irq_d;

  logic              sel_c, wr_c;
  logic [2:0]        ofs_c;
  logic              wr_tctrl_c, wr_tload_c, wr_tstat_c;
  logic              running_c, start_c, stop_c, tick_c, expire_c;
  logic [DATA_W-1:0] rdata_c;

  // Bus decode
  assign sel_c      = addr_hit(mem_addr, BASE_ADDR, LAST_OFS);
  assign ofs_c      = mem_addr[2:0];
  assign wr_c       = (mem_cmd == MWRITE) && sel_c;
  assign wr_tctrl_c = wr_c && (ofs_c == TCTRL_OFS);
  assign wr_tload_c = wr_c && (ofs_c == TLOAD_OFS);
  assign wr_tstat_c = wr_c && (ofs_c == TSTAT_OFS);

  assign running_c = (state_q == RUN);
  assign start_c   = wr_tctrl_c && write_data[TCTRL_EN_BIT] && !running_c;
  assign stop_c    = wr_tctrl_c && !write_data[TCTRL_EN_BIT];
  assign expire_c  = tick_c && (tcount_q == '0) && !stop_c;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .en    (running_c),
    .tick  (tick_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a TCTRL write overrides a same-cycle one-shot expiry
  always_comb begin
    state_d = state_q;
    if (wr_tctrl_c) begin
      state_d = write_data[TCTRL_EN_BIT] ? RUN : IDLE;
    end else if (expire_c && !ar_q) begin
      state_d = IDLE;
    end
  end

  // Register next values
  always_comb begin
    ar_d     = ar_q;
    ie_d     = ie_q;
    tload_d  = tload_q;
    tcount_d = tcount_q;
    exp_d    = exp_q;

    if (wr_tctrl_c) begin
      ar_d = write_data[TCTRL_AR_BIT];
      ie_d = write_data[TCTRL_IE_BIT];
    end

    if (wr_tload_c) tload_d = write_data;

    // Start reload beats ticking; TLOAD writes mirror into TCOUNT only while idle
    if (start_c) begin
      tcount_d = tload_q;
    end else if (wr_tload_c && !running_c) begin
      tcount_d = write_data;
    end else if (tick_c && !stop_c) begin
      if (tcount_q != '0) tcount_d = tcount_q - DATA_W'(1);
      else if (ar_q)      tcount_d = tload_q;
    end

    // Expiry set wins over a same-edge W1C
    if (wr_tstat_c && write_data[TSTAT_EXP_BIT]) exp_d = 1'b0;
    if (expire_c)                                exp_d = 1'b1;

    irq_d = exp_d && ie_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar_q     <= 1'b0;
      ie_q     <= 1'b0;
      tload_q  <= '0;
      tcount_q <= '0;
      exp_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ar_q     <= ar_d;
      ie_q     <= ie_d;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      exp_q    <= exp_d;
      irq_q    <= irq_d;
    end
  end

  assign timer_irq = irq_q;

`ifdef TIMER_PWM_EN
  logic [DATA_W-1:0] tcmp_q, tcmp_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    tcmp_d = tcmp_q;
    if (wr_c && (ofs_c == TCMP_OFS)) tcmp_d = write_data;
    pwm_d = running_c && (tcount_q < tcmp_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcmp_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      tcmp_q <= tcmp_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

  // Read mux; offsets outside the map never reach the bus because sel_c is low
  always_comb begin
    rdata_c = '0;
    case (ofs_c)
      TCTRL_OFS:  rdata_c = {13'b0, ie_q, ar_q, running_c};
      TLOAD_OFS:  rdata_c = tload_q;
      TCOUNT_OFS: rdata_c = tcount_q;
      TSTAT_OFS:  rdata_c = {15'b0, exp_q};
`ifdef TIMER_PWM_EN
      TCMP_OFS:   rdata_c = tcmp_q;
`endif
      default:    rdata_c = '0;
    endcase
  end

  assign read_data = ((mem_cmd == MREAD) && sel_c) ? rdata_c : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: self-checking bench for mmio_timer. Two instances share
// the bus inputs: u_p1 (PRESCALE=1) and u_p4 (PRESCALE=4).
`timescale 1ns/1ps
module tb_mmio_timer;
  import mmio_pkg::*;

  localparam logic [8:0] BASE = 9'h180;
  localparam logic [8:0] A_CTRL = BASE + 9'd0;
  localparam logic [8:0] A_LOAD = BASE + 9'd1;
  localparam logic [8:0] A_CNT  = BASE + 9'd2;
  localparam logic [8:0] A_STAT = BASE + 9'd3;
  localparam logic [8:0] A_CMP  = BASE + 9'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  wire  [15:0] rd1, rd4;
  wire         irq1, irq4, pwm1, pwm4;
  wire         z1 = (rd1 === 16'bz);
  wire         z4 = (rd4 === 16'bz);

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        p4;
    logic        ez;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic        p4;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        ez;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(rd1), .timer_irq(irq1), .pwm_out(pwm1));

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(rd4), .timer_irq(irq4), .pwm_out(pwm4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rd(input exp_t x);
    logic        az;
    logic [15:0] av;
    az = x.p4 ? z4 : z1;
    av = x.p4 ? rd4 : rd1;
    n_vec++;
    if (x.ez ? !az : (az || (av !== x.data))) begin
      n_bad++;
      $display("FAIL %s: got %h (z=%0b) expected %h (z=%0b)", x.name, av, az, x.data, x.ez);
    end
  endtask

  // Drive a read, record the expectation, then compare once the bus settles
  task automatic rd(input logic p4, input logic [8:0] a, input logic ez,
                    input logic [15:0] e, input string nm);
    exp_t x;
    mem_cmd  = MREAD;
    mem_addr = a;
    x.name = nm; x.p4 = p4; x.ez = ez; x.data = e;
    sb.push_back(x);
    #1;
    check_rd(sb.pop_front());
    mem_cmd  = MNONE;
    mem_addr = '0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    mem_cmd = MWRITE; mem_addr = a; write_data = d;
    @(posedge clk); #1;
    mem_cmd = MNONE; mem_addr = '0; write_data = '0;
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic add(input logic w, input logic p4, input logic [8:0] a,
                     input logic [15:0] d, input logic ez, input logic [15:0] e,
                     input string nm);
    vec_t v;
    v.wr = w; v.p4 = p4; v.addr = a; v.wdata = d; v.ez = ez; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; mem_cmd = MNONE; mem_addr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset values, decode and register access
    add(0, 0, A_CTRL, 0, 0, 16'h0000, "rst tctrl");
    add(0, 0, A_LOAD, 0, 0, 16'h0000, "rst tload");
    add(0, 0, A_CNT,  0, 0, 16'h0000, "rst tcount");
    add(0, 0, A_STAT, 0, 0, 16'h0000, "rst tstat");
    add(0, 1, A_CTRL, 0, 0, 16'h0000, "rst p4 tctrl");
    add(0, 1, A_CNT,  0, 0, 16'h0000, "rst p4 tcount");
    add(0, 0, 9'h100, 0, 1, 16'h0000, "led addr z");
    add(0, 0, 9'h140, 0, 1, 16'h0000, "sw addr z");
    add(0, 0, BASE + 9'd5, 0, 1, 16'h0000, "ofs5 z");
    add(0, 0, BASE - 9'd1, 0, 1, 16'h0000, "below base z");
`ifdef TIMER_PWM_EN
    add(0, 0, A_CMP, 0, 0, 16'h0000, "rst tcmp");
    add(1, 0, A_CMP, 16'h00A5, 0, 0, "");
    add(0, 0, A_CMP, 0, 0, 16'h00A5, "tcmp rw");
    add(1, 0, A_CMP, 16'h0000, 0, 0, "");
`else
    add(0, 0, A_CMP, 0, 1, 16'h0000, "ofs4 unmapped z");
`endif
    add(1, 0, A_CTRL, 16'hFFF6, 0, 0, "");
    add(0, 0, A_CTRL, 0, 0, 16'h0006, "tctrl mask");
    add(1, 0, A_LOAD, 16'hBEEF, 0, 0, "");
    add(0, 0, A_LOAD, 0, 0, 16'hBEEF, "tload rw");
    add(0, 0, A_CNT,  0, 0, 16'hBEEF, "idle tload copy");
    add(1, 0, A_CNT,  16'h1234, 0, 0, "");
    add(0, 0, A_CNT,  0, 0, 16'hBEEF, "tcount ro");
    add(1, 0, A_STAT, 16'h0001, 0, 0, "");
    add(0, 0, A_STAT, 0, 0, 16'h0000, "tstat w1c idle");
    add(1, 0, A_CTRL, 16'h0000, 0, 0, "");
    add(1, 0, A_LOAD, 16'h0000, 0, 0, "");
    add(0, 0, A_CNT,  0, 0, 16'h0000, "tcount cleared");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].wdata);
      end else begin
        rd(tbl[i].p4, tbl[i].addr, tbl[i].ez, tbl[i].exp, tbl[i].name);
        @(negedge clk);
      end
    end
    chk("rst irq", int'(irq1), 0);
    chk("rst pwm", int'(pwm1), 0);

    // One-shot countdown, PRESCALE=1
    wr(A_LOAD, 16'd3);
    wr(A_CTRL, 16'h0001);
    rd(0, A_CNT, 0, 16'd3, "t2 cnt3"); step(1);
    rd(0, A_CNT, 0, 16'd2, "t2 cnt2"); step(1);
    rd(0, A_CNT, 0, 16'd1, "t2 cnt1"); step(1);
    rd(0, A_CNT, 0, 16'd0, "t2 cnt0");
    rd(0, A_STAT, 0, 16'd0, "t2 exp early"); step(1);
    rd(0, A_STAT, 0, 16'd1, "t2 exp set");
    rd(0, A_CTRL, 0, 16'd0, "t2 en cleared");
    rd(0, A_CNT, 0, 16'd0, "t2 cnt held"); step(3);
    rd(0, A_CNT, 0, 16'd0, "t2 cnt stays");

    // Auto-reload with interrupt, W1C vs expiry
    wr(A_STAT, 16'h0001);
    wr(A_LOAD, 16'd2);
    wr(A_CTRL, 16'h0007);
    step(2);
    rd(0, A_STAT, 0, 16'd0, "t3 exp early");
    chk("t3 irq early", int'(irq1), 0);
    step(1);
    rd(0, A_STAT, 0, 16'd1, "t3 exp1");
    chk("t3 irq1", int'(irq1), 1);
    rd(0, A_CNT, 0, 16'd2, "t3 reload");
    wr(A_STAT, 16'h0001);
    rd(0, A_STAT, 0, 16'd0, "t3 w1c");
    chk("t3 irq clr", int'(irq1), 0);
    rd(0, A_CNT, 0, 16'd1, "t3 cnt1");
    step(1);
    wr(A_STAT, 16'h0001);
    rd(0, A_STAT, 0, 16'd1, "t3 set beats w1c");
    chk("t3 irq2", int'(irq1), 1);
    rd(0, A_CTRL, 0, 16'h0007, "t3 still run");
    wr(A_STAT, 16'h0000);
    rd(0, A_STAT, 0, 16'd1, "t3 w0 no effect");
    wr(A_CTRL, 16'h0000);

    // PRESCALE=4 latency, then stop before expiry
    do_reset();
    wr(A_LOAD, 16'd1);
    wr(A_CTRL, 16'h0001);
    step(7);
    rd(1, A_STAT, 0, 16'd0, "t4 exp early");
    rd(1, A_CNT, 0, 16'd0, "t4 cnt0");
    step(1);
    rd(1, A_STAT, 0, 16'd1, "t4 exp edge8");
    rd(1, A_CTRL, 0, 16'd0, "t4 en cleared");
    wr(A_STAT, 16'h0001);
    wr(A_CTRL, 16'h0001);
    rd(1, A_CNT, 0, 16'd1, "t4 restart reload");
    step(4);
    rd(1, A_CNT, 0, 16'd0, "t4 cnt edge4");
    wr(A_CTRL, 16'h0000);
    rd(1, A_CTRL, 0, 16'd0, "t4 stopped");
    step(10);
    rd(1, A_STAT, 0, 16'd0, "t4 never exp");
    rd(1, A_CNT, 0, 16'd0, "t4 cnt frozen");

    // Asynchronous reset mid-count
    do_reset();
    wr(A_LOAD, 16'd5);
    wr(A_CTRL, 16'h0007);
    step(7);
    rd(0, A_CNT, 0, 16'd4, "t5 pre cnt");
    chk("t5 pre irq", int'(irq1), 1);
    reset = 1'b0;
    rd(0, A_CNT, 0, 16'd0, "t5 async cnt");
    chk("t5 async irq", int'(irq1), 0);
    chk("t5 async pwm", int'(pwm1), 0);
    rd(0, A_STAT, 0, 16'd0, "t5 async stat");
    rd(0, A_CTRL, 0, 16'd0, "t5 async ctrl");
    @(negedge clk);
    reset = 1'b1;
    step(2);
    rd(0, A_CNT, 0, 16'd0, "t5 no resume");
    rd(0, A_LOAD, 0, 16'd0, "t5 tload clr");
    wr(A_LOAD, 16'd2);
    step(2);
    rd(0, A_CNT, 0, 16'd2, "t5 idle hold");
    wr(A_CTRL, 16'h0001);
    rd(0, A_CNT, 0, 16'd2, "t5 start");
    step(1);
    rd(0, A_CNT, 0, 16'd1, "t5 resumed");
    wr(A_CTRL, 16'h0000);

    // PWM output
    do_reset();
`ifdef TIMER_PWM_EN
    wr(A_CMP, 16'd3);
    wr(A_LOAD, 16'd7);
    wr(A_CTRL, 16'h0003);
    step(8);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(1); if (pwm1) cnt++; end
    chk("t6 pwm duty", cnt, 6);
    wr(A_CMP, 16'd0);
    step(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(1); if (pwm1) cnt++; end
    chk("t6 pwm cmp0", cnt, 0);
    rd(0, A_CMP, 0, 16'd0, "t6 tcmp read");
`else
    wr(A_CMP, 16'd3);
    wr(A_LOAD, 16'd7);
    wr(A_CTRL, 16'h0003);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(1); if (pwm1) cnt++; end
    chk("t6 pwm tied low", cnt, 0);
    rd(0, A_CMP, 1, 16'd0, "t6 ofs4 z");
    rd(0, A_CTRL, 0, 16'h0003, "t6 ofs4 write ignored");
`endif
    wr(A_CTRL, 16'h0000);
    chk("t6 pwm idle", int'(pwm1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
